pong_game_ctrl: RTL

- Game-state controller that drives the game_control side of pong_intf: owns ball and paddle positions, sequences serve/play/miss/game-over, keeps score and lives.
- Advances once per video frame on frame_tick, a 1-cycle pulse from vga_sync at end of the visible frame.
- vga_rgb consumes ball/pad directly.

---
 rtl/pong_pkg.sv | 35 +++
 rtl/pong_ball_step.sv | 80 ++++++++
 rtl/pong_game_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared types and playfield geometry for the pong game controller and its ball stepper.
package pong_pkg;

    localparam int H_MAX     = 640;
    localparam int V_MAX     = 480;
    localparam int BALL_SIZE = 8;
    localparam int PAD_X     = 600;
    localparam int PAD_W     = 4;
    localparam int PAD_H     = 64;

    localparam logic [9:0] BALL_X0 = 10'((H_MAX - BALL_SIZE) / 2);
    localparam logic [9:0] BALL_Y0 = 10'((V_MAX - BALL_SIZE) / 2);
    localparam logic [9:0] PAD_Y0  = 10'd208;

    typedef struct packed {
        logic [1:0] speed_x;
        logic [1:0] speed_y;
    } init_speed;

    typedef struct packed {
        logic       hsync;
        logic       vsync;
        logic       video_on;
        logic [9:0] pix_x;
        logic [9:0] pix_y;
    } sync_data;

    typedef struct packed {
        logic [9:0] pos_x;
        logic [9:0] pos_y;
    } pos_data;

    typedef enum logic [2:0] {IDLE, SERVE, PLAY, MISS, OVER} game_state_e;

endpackage

// File: rtl/pong_ball_step.sv
// Combinational one-frame ball update: wall bounces, paddle hit and right-edge miss.
module pong_ball_step
    import pong_pkg::*;
(
    input  pos_data    i_ball,
    input  logic [9:0] i_pad_y,
    input  logic [2:0] i_vx,
    input  logic [2:0] i_vy,
    input  logic       i_dir_x,
    input  logic       i_dir_y,
    output pos_data    o_ball,
    output logic       o_dir_x,
    output logic       o_dir_y,
    output logic       o_hit,
    output logic       o_miss
);
    localparam logic [10:0] SZ      = 11'(BALL_SIZE);
    localparam logic [10:0] X_LIM   = 11'(H_MAX - BALL_SIZE);
    localparam logic [10:0] Y_LIM   = 11'(V_MAX - BALL_SIZE);
    localparam logic [10:0] PAD_L   = 11'(PAD_X);
    localparam logic [10:0] PAD_LEN = 11'(PAD_H);

    logic [10:0] w_x, w_y, w_vx, w_vy, w_pad_y;
    logic [9:0]  w_x_nxt, w_y_nxt;
    logic        w_overlap;

    assign w_x     = {1'b0, i_ball.pos_x};
    assign w_y     = {1'b0, i_ball.pos_y};
    assign w_vx    = {8'd0, i_vx};
    assign w_vy    = {8'd0, i_vy};
    assign w_pad_y = {1'b0, i_pad_y};

    // Overlap uses the paddle position from before this frame's paddle move.
    assign w_overlap = (w_y + SZ > w_pad_y) && (w_y < w_pad_y + PAD_LEN);
    assign o_hit     = i_dir_x && (w_x + SZ <= PAD_L) && (w_x + SZ + w_vx >= PAD_L) && w_overlap;
    assign o_miss    = i_dir_x && !o_hit && (w_x + w_vx >= X_LIM);

    // dir_y: 1 = down
    always_comb begin
        w_y_nxt = i_ball.pos_y;
        o_dir_y = i_dir_y;
        if (!i_dir_y) begin
            if (w_y <= w_vy) begin
                w_y_nxt = '0;
                o_dir_y = 1'b1;
            end else begin
                w_y_nxt = 10'(w_y - w_vy);
            end
        end else if (w_y + w_vy >= Y_LIM) begin
            w_y_nxt = 10'(Y_LIM);
            o_dir_y = 1'b0;
        end else begin
            w_y_nxt = 10'(w_y + w_vy);
        end
    end

    // dir_x: 1 = right
    always_comb begin
        w_x_nxt = i_ball.pos_x;
        o_dir_x = i_dir_x;
        if (!i_dir_x) begin
            if (w_x <= w_vx) begin
                w_x_nxt = '0;
                o_dir_x = 1'b1;
            end else begin
                w_x_nxt = 10'(w_x - w_vx);
            end
        end else if (o_hit) begin
            w_x_nxt = 10'(PAD_L - SZ);
            o_dir_x = 1'b0;
        end else if (o_miss) begin
            w_x_nxt = 10'(X_LIM);
        end else begin
            w_x_nxt = 10'(w_x + w_vx);
        end
    end

    assign o_ball = '{pos_x: w_x_nxt, pos_y: w_y_nxt};

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve/play/miss/over FSM, paddle control, score and lives, stepped per frame.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int SERVE_FRAMES = 60,
    parameter int MISS_FRAMES  = 30,
    parameter int PAD_STEP     = 4,
    parameter int LIVES        = 3
)
(
    input  logic      clk,
    input  logic      reset,
    input  logic      frame_tick,
    input  init_speed start_speed,
    input  logic      btn_start,
    input  logic      btn_up,
    input  logic      btn_down,
    output pos_data   ball,
    output pos_data   pad,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic      game_over
);
    localparam logic [7:0]  SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0]  MISS_LAST  = 8'(MISS_FRAMES - 1);
    localparam logic [10:0] PAD_Y_MAX  = 11'(V_MAX - PAD_H);
    localparam logic [10:0] STEP       = 11'(PAD_STEP);
    localparam logic [1:0]  LIVES_INIT = 2'(LIVES);

    game_state_e r_state, w_state_nxt;
    pos_data     r_ball, w_ball_nxt, w_step_ball;
    logic [9:0]  r_pad_y, w_pad_y_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt, r_score, w_score_nxt;
    logic [1:0]  r_lives, w_lives_nxt;
    logic [2:0]  r_vx, r_vy, w_vx_nxt, w_vy_nxt;
    logic        r_dir_x, r_dir_y, w_dir_x_nxt, w_dir_y_nxt;
    logic        r_btn_start_d, r_game_over;
    logic        w_start_pe, w_enter_serve, w_step_dir_x, w_step_dir_y, w_hit, w_miss;
    logic [10:0] w_pad_ext;

    assign w_start_pe = btn_start && !r_btn_start_d;
    assign w_pad_ext  = {1'b0, r_pad_y};

    pong_ball_step u_step (
        .i_ball  (r_ball),
        .i_pad_y (r_pad_y),
        .i_vx    (r_vx),
        .i_vy    (r_vy),
        .i_dir_x (r_dir_x),
        .i_dir_y (r_dir_y),
        .o_ball  (w_step_ball),
        .o_dir_x (w_step_dir_x),
        .o_dir_y (w_step_dir_y),
        .o_hit   (w_hit),
        .o_miss  (w_miss)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_ball        <= '{pos_x: BALL_X0, pos_y: BALL_Y0};
            r_pad_y       <= PAD_Y0;
            r_cnt         <= '0;
            r_score       <= '0;
            r_lives       <= LIVES_INIT;
            r_vx          <= 3'd1;
            r_vy          <= 3'd1;
            r_dir_x       <= 1'b0;
            r_dir_y       <= 1'b1;
            r_btn_start_d <= 1'b0;
            r_game_over   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ball        <= w_ball_nxt;
            r_pad_y       <= w_pad_y_nxt;
            r_cnt         <= w_cnt_nxt;
            r_score       <= w_score_nxt;
            r_lives       <= w_lives_nxt;
            r_vx          <= w_vx_nxt;
            r_vy          <= w_vy_nxt;
            r_dir_x       <= w_dir_x_nxt;
            r_dir_y       <= w_dir_y_nxt;
            r_btn_start_d <= btn_start;
            r_game_over   <= (w_state_nxt == OVER);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ball_nxt    = r_ball;
        w_pad_y_nxt   = r_pad_y;
        w_cnt_nxt     = r_cnt;
        w_score_nxt   = r_score;
        w_lives_nxt   = r_lives;
        w_vx_nxt      = r_vx;
        w_vy_nxt      = r_vy;
        w_dir_x_nxt   = r_dir_x;
        w_dir_y_nxt   = r_dir_y;
        w_enter_serve = 1'b0;

        case (r_state)
            IDLE, OVER: begin
                if (w_start_pe) begin
                    w_enter_serve = 1'b1;
                    w_score_nxt   = '0;
                    w_lives_nxt   = LIVES_INIT;
                end
            end
            SERVE: begin
                if (frame_tick) begin
                    if (r_cnt == SERVE_LAST) begin
                        w_state_nxt = PLAY;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
            end
            PLAY: begin
                if (frame_tick) begin
                    w_ball_nxt  = w_step_ball;
                    w_dir_x_nxt = w_step_dir_x;
                    w_dir_y_nxt = w_step_dir_y;
                    if (w_hit && r_score != 8'hFF)
                        w_score_nxt = r_score + 8'd1;
                    if (w_miss) begin
                        w_state_nxt = MISS;
                        w_lives_nxt = r_lives - 2'd1;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            MISS: begin
                if (frame_tick) begin
                    if (r_cnt == MISS_LAST) begin
                        w_cnt_nxt = '0;
                        if (r_lives == 2'd0)
                            w_state_nxt = OVER;
                        else
                            w_enter_serve = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Every way into SERVE recentres the ball and relatches the serve velocity.
        if (w_enter_serve) begin
            w_state_nxt = SERVE;
            w_cnt_nxt   = '0;
            w_ball_nxt  = '{pos_x: BALL_X0, pos_y: BALL_Y0};
            w_dir_x_nxt = 1'b0;
            w_dir_y_nxt = 1'b1;
            w_vx_nxt    = {1'b0, start_speed.speed_x} + 3'd1;
            w_vy_nxt    = {1'b0, start_speed.speed_y} + 3'd1;
        end

        if (frame_tick && (r_state == SERVE || r_state == PLAY)) begin
            if (btn_up && !btn_down)
                w_pad_y_nxt = (w_pad_ext <= STEP) ? '0 : 10'(w_pad_ext - STEP);
            else if (btn_down && !btn_up)
                w_pad_y_nxt = (w_pad_ext + STEP >= PAD_Y_MAX) ? 10'(PAD_Y_MAX) : 10'(w_pad_ext + STEP);
        end
    end

    assign ball      = r_ball;
    assign pad       = '{pos_x: 10'(PAD_X), pos_y: r_pad_y};
    assign score     = r_score;
    assign lives     = r_lives;
    assign game_over = r_game_over;

endmodule
